bp_update_scheduler: RTL and testbench

BP_UPDATE_SCHEDULER -- requirements
Module: bp_update_scheduler

---
 rtl/bp_update_scheduler_if.sv | 46 ++++
 rtl/bp_update_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_bp_update_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_update_scheduler_if.sv
// Update/table bus for bp_update_scheduler.
//   upd_*       : resolved branch updates from EX (valid/ready handshake)
//   init_req    : one-cycle request to re-initialize all tables
//   init_busy   : tables invalid, fetch ignores predictions
//   tbl_rd_*    : combinational BHT read at the FIFO head index
//   tbl_*       : registered single write port to tag/BTB/BHT tables
//   mispred_cnt : saturating count of accepted mispredicted updates
// master = update/table side, slave = scheduler.
interface bp_update_scheduler_if #(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned TAG_W = 8
);
    localparam int unsigned WORD_SIZE = IDX_W + TAG_W;
    localparam int unsigned CNT_W     = 16;

    logic                 upd_valid;
    logic [WORD_SIZE-1:0] upd_pc;
    logic [WORD_SIZE-1:0] upd_target;
    logic                 upd_taken;
    logic                 upd_mispred;
    logic                 upd_ready;
    logic                 init_req;
    logic                 init_busy;
    logic [IDX_W-1:0]     tbl_rd_idx;
    logic [1:0]           tbl_rd_bht;
    logic                 tbl_we;
    logic [IDX_W-1:0]     tbl_idx;
    logic [TAG_W-1:0]     tbl_tag;
    logic [IDX_W-1:0]     tbl_target;
    logic [1:0]           tbl_bht;
    logic [CNT_W-1:0]     mispred_cnt;

    modport master (
        output upd_valid, upd_pc, upd_target, upd_taken, upd_mispred,
        output init_req, tbl_rd_bht,
        input  upd_ready, init_busy, tbl_rd_idx,
        input  tbl_we, tbl_idx, tbl_tag, tbl_target, tbl_bht, mispred_cnt
    );

    modport slave (
        input  upd_valid, upd_pc, upd_target, upd_taken, upd_mispred,
        input  init_req, tbl_rd_bht,
        output upd_ready, init_busy, tbl_rd_idx,
        output tbl_we, tbl_idx, tbl_tag, tbl_target, tbl_bht, mispred_cnt
    );
endinterface

// File: rtl/bp_update_scheduler.sv
// Branch-predictor update scheduler.
// Sweeps the tag/BTB/BHT tables to a known state after reset or init_req,
// then queues resolved updates in a 2-entry FIFO and retires one per cycle
// as a table write with a saturating 2-bit BHT update.
// Ports:
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : bp_update_scheduler_if.slave (updates, init, table ports, counter)
module bp_update_scheduler #(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned TAG_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    bp_update_scheduler_if.slave   bus
);
    localparam int unsigned WORD_SIZE  = IDX_W + TAG_W;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FCNT_W     = 2;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] target;
        logic             taken;
    } upd_entry_t;

    // 2-bit saturating counter step
    function automatic logic [1:0] sat_step(input logic [1:0] v, input logic taken);
        logic [1:0] r;
        if (taken) r = (v == 2'b11) ? 2'b11 : v + 2'd1;
        else       r = (v == 2'b00) ? 2'b00 : v - 2'd1;
        return r;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_sweep_cnt;
    logic [IDX_W-1:0]   w_sweep_nxt;

    upd_entry_t         r_fifo [FIFO_DEPTH];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [FCNT_W-1:0]  r_count;
    logic [FCNT_W-1:0]  w_count_nxt;

    logic               r_tbl_we;
    logic [IDX_W-1:0]   r_tbl_idx;
    logic [TAG_W-1:0]   r_tbl_tag;
    logic [IDX_W-1:0]   r_tbl_target;
    logic [1:0]         r_tbl_bht;
    logic               w_tbl_we_nxt;
    logic [IDX_W-1:0]   w_tbl_idx_nxt;
    logic [TAG_W-1:0]   w_tbl_tag_nxt;
    logic [IDX_W-1:0]   w_tbl_target_nxt;
    logic [1:0]         w_tbl_bht_nxt;

    logic               r_upd_ready;
    logic               r_init_busy;
    logic [CNT_W-1:0]   r_mispred_cnt;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    upd_entry_t         w_head;
    upd_entry_t         w_push_entry;
    logic [1:0]         w_old_bht;
    logic               w_unused;

    assign w_head   = r_fifo[r_rd_ptr];
    assign w_accept = bus.upd_valid && r_upd_ready;
    assign w_push   = w_accept && !w_flush;

    assign w_push_entry.idx    = bus.upd_pc[IDX_W-1:0];
    assign w_push_entry.tag    = bus.upd_pc[WORD_SIZE-1:IDX_W];
    assign w_push_entry.target = bus.upd_target[IDX_W-1:0];
    assign w_push_entry.taken  = bus.upd_taken;

    // Only the low target bits are stored in the BTB
    assign w_unused = ^bus.upd_target[WORD_SIZE-1:IDX_W];

    // Forward the in-flight write when it targets the head index
    assign w_old_bht = (r_tbl_we && (r_tbl_idx == w_head.idx)) ? r_tbl_bht : bus.tbl_rd_bht;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_INIT;
        else          r_state <= w_state_nxt;
    end

    // Next state, sweep counter, FIFO pop/flush and table write selection
    always_comb begin
        w_state_nxt      = r_state;
        w_sweep_nxt      = r_sweep_cnt;
        w_tbl_we_nxt     = 1'b0;
        w_tbl_idx_nxt    = r_tbl_idx;
        w_tbl_tag_nxt    = r_tbl_tag;
        w_tbl_target_nxt = r_tbl_target;
        w_tbl_bht_nxt    = r_tbl_bht;
        w_pop            = 1'b0;
        w_flush          = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_tbl_we_nxt     = 1'b1;
                w_tbl_idx_nxt    = r_sweep_cnt;
                w_tbl_tag_nxt    = '1;
                w_tbl_target_nxt = '0;
                w_tbl_bht_nxt    = 2'b01;
                w_sweep_nxt      = r_sweep_cnt + IDX_W'(1);
                if (r_sweep_cnt == '1) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.init_req) begin
                    w_flush     = 1'b1;
                    w_sweep_nxt = '0;
                    w_state_nxt = ST_INIT;
                end else if (r_count != '0) begin
                    w_pop            = 1'b1;
                    w_tbl_we_nxt     = 1'b1;
                    w_tbl_idx_nxt    = w_head.idx;
                    w_tbl_tag_nxt    = w_head.tag;
                    w_tbl_target_nxt = w_head.target;
                    w_tbl_bht_nxt    = sat_step(w_old_bht, w_head.taken);
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_sweep_nxt = '0;
            end
        endcase
    end

    // FIFO occupancy
    always_comb begin
        w_count_nxt = r_count;
        if (w_flush) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + FCNT_W'(1);
                2'b01:   w_count_nxt = r_count - FCNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_flush) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_fifo[r_wr_ptr] <= w_push_entry;
                    r_wr_ptr         <= ~r_wr_ptr;
                end
                if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // Table write port, handshake/status flags and mispredict counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sweep_cnt   <= '0;
            r_tbl_we      <= 1'b0;
            r_tbl_idx     <= '0;
            r_tbl_tag     <= '0;
            r_tbl_target  <= '0;
            r_tbl_bht     <= 2'b01;
            r_upd_ready   <= 1'b0;
            r_init_busy   <= 1'b1;
            r_mispred_cnt <= '0;
        end else begin
            r_sweep_cnt  <= w_sweep_nxt;
            r_tbl_we     <= w_tbl_we_nxt;
            r_tbl_idx    <= w_tbl_idx_nxt;
            r_tbl_tag    <= w_tbl_tag_nxt;
            r_tbl_target <= w_tbl_target_nxt;
            r_tbl_bht    <= w_tbl_bht_nxt;
            // ready/busy are registered images of next state and occupancy
            r_upd_ready  <= (w_state_nxt == ST_RUN) && (w_count_nxt != FCNT_W'(FIFO_DEPTH));
            r_init_busy  <= (w_state_nxt != ST_RUN);
            if (w_accept && bus.upd_mispred && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

    assign bus.upd_ready   = r_upd_ready;
    assign bus.init_busy   = r_init_busy;
    assign bus.tbl_rd_idx  = w_head.idx;
    assign bus.tbl_we      = r_tbl_we;
    assign bus.tbl_idx     = r_tbl_idx;
    assign bus.tbl_tag     = r_tbl_tag;
    assign bus.tbl_target  = r_tbl_target;
    assign bus.tbl_bht     = r_tbl_bht;
    assign bus.mispred_cnt = r_mispred_cnt;
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed self-checking bench for bp_update_scheduler.
module tb_bp_update_scheduler;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    bp_update_scheduler_if bus ();

    bp_update_scheduler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input logic v, input logic [15:0] pc, input logic [15:0] tgt,
                             input logic tk, input logic mp);
        bus.upd_valid   = v;
        bus.upd_pc      = pc;
        bus.upd_target  = tgt;
        bus.upd_taken   = tk;
        bus.upd_mispred = mp;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.tbl_target, bus.tbl_bht} !== {1'b0, 8'h00, 8'h00, 8'h00, 2'b01}) begin
            n_fail++;
            $display("FAIL reset_tbl: got we=%b idx=%h tag=%h tgt=%h bht=%b, expected 0/00/00/00/01",
                     bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.tbl_target, bus.tbl_bht);
        end
        n_checks++;
        if ({bus.upd_ready, bus.init_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_flags: got ready=%b busy=%b, expected 0/1", bus.upd_ready, bus.init_busy);
        end
        n_checks++;
        if (bus.mispred_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mispred: got %h expected 0000", bus.mispred_cnt);
        end
    endtask

    task automatic test_init_sweep();
        int errs;
        errs = 0;
        reset_n = 1'b1;
        for (int k = 0; k < 256; k++) begin
            tick();
            n_checks++;
            if ({bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.tbl_target, bus.tbl_bht, bus.init_busy, bus.upd_ready}
                !== {1'b1, 8'(k), 8'hFF, 8'h00, 2'b01, 1'b1, 1'b0}) begin
                n_fail++;
                if (errs++ < 4)
                    $display("FAIL sweep_%0d: got we=%b idx=%h tag=%h tgt=%h bht=%b busy=%b rdy=%b, expected 1/%h/ff/00/01/1/0",
                             k, bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.tbl_target, bus.tbl_bht,
                             bus.init_busy, bus.upd_ready, 8'(k));
            end
        end
        tick();
        n_checks++;
        if ({bus.tbl_we, bus.init_busy, bus.upd_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL sweep_done: got we=%b busy=%b ready=%b, expected 0/0/1",
                     bus.tbl_we, bus.init_busy, bus.upd_ready);
        end
    endtask

    task automatic test_single_update();
        bus.tbl_rd_bht = 2'b01;
        drive_upd(1'b1, 16'h1234, 16'h1250, 1'b1, 1'b0);
        n_checks++;
        if (bus.upd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 1", bus.upd_ready);
        end
        tick();
        drive_upd(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if ({bus.tbl_we, bus.tbl_rd_idx} !== {1'b0, 8'h34}) begin
            n_fail++;
            $display("FAIL single_head: got we=%b rd_idx=%h expected 0/34", bus.tbl_we, bus.tbl_rd_idx);
        end
        tick();
        n_checks++;
        if ({bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.tbl_target, bus.tbl_bht} !== {1'b1, 8'h34, 8'h12, 8'h50, 2'b10}) begin
            n_fail++;
            $display("FAIL single_write: got we=%b idx=%h tag=%h tgt=%h bht=%b, expected 1/34/12/50/10",
                     bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.tbl_target, bus.tbl_bht);
        end
        tick();
        n_checks++;
        if (bus.tbl_we !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got we=%b expected 0", bus.tbl_we);
        end
    endtask

    task automatic test_forwarding();
        bus.tbl_rd_bht = 2'b01;
        drive_upd(1'b1, 16'h1234, 16'h1250, 1'b1, 1'b0);
        tick();
        tick();
        drive_upd(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if ({bus.tbl_we, bus.tbl_idx, bus.tbl_bht} !== {1'b1, 8'h34, 2'b10}) begin
            n_fail++;
            $display("FAIL fwd_first: got we=%b idx=%h bht=%b, expected 1/34/10", bus.tbl_we, bus.tbl_idx, bus.tbl_bht);
        end
        tick();
        n_checks++;
        if ({bus.tbl_we, bus.tbl_idx, bus.tbl_bht} !== {1'b1, 8'h34, 2'b11}) begin
            n_fail++;
            $display("FAIL fwd_second: got we=%b idx=%h bht=%b, expected 1/34/11", bus.tbl_we, bus.tbl_idx, bus.tbl_bht);
        end
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] rd_v  [6];
        logic       tk_v  [6];
        logic [1:0] exp_v [6];
        rd_v = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b11, 2'b01};
        tk_v = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
        exp_v = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 6; i++) begin
            bus.tbl_rd_bht = rd_v[i];
            drive_upd(1'b1, 16'hA040 + 16'(i), 16'h0000, tk_v[i], 1'b0);
            tick();
            drive_upd(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            tick();
            n_checks++;
            if ({bus.tbl_we, bus.tbl_idx, bus.tbl_bht} !== {1'b1, 8'h40 + 8'(i), exp_v[i]}) begin
                n_fail++;
                $display("FAIL sat_%0d: got we=%b idx=%h bht=%b, expected 1/%h/%b",
                         i, bus.tbl_we, bus.tbl_idx, bus.tbl_bht, 8'h40 + 8'(i), exp_v[i]);
            end
            tick();
        end
        bus.tbl_rd_bht = 2'b01;
    endtask

    task automatic test_back_to_back();
        logic [7:0] e_idx;
        logic [1:0] e_bht;
        bus.tbl_rd_bht = 2'b01;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                drive_upd(1'b1, 16'h0110 + 16'h0101 * 16'(i), 16'h0020 + 16'(i), (i % 2) == 0, 1'b0);
                n_checks++;
                if (bus.upd_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready_%0d: got %b expected 1", i, bus.upd_ready);
                end
            end else begin
                drive_upd(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            end
            tick();
            if (i > 0) begin
                e_idx = 8'h10 + 8'(i - 1);
                e_bht = (((i - 1) % 2) == 0) ? 2'b10 : 2'b00;
                n_checks++;
                if ({bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.tbl_target, bus.tbl_bht}
                    !== {1'b1, e_idx, 8'h01 + 8'(i - 1), 8'h20 + 8'(i - 1), e_bht}) begin
                    n_fail++;
                    $display("FAIL b2b_write_%0d: got we=%b idx=%h tag=%h tgt=%h bht=%b, expected idx=%h bht=%b",
                             i - 1, bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.tbl_target, bus.tbl_bht, e_idx, e_bht);
                end
            end
        end
        tick();
    endtask

    task automatic test_init_discard();
        int errs;
        errs = 0;
        drive_upd(1'b1, 16'h5566, 16'h0077, 1'b1, 1'b0);
        tick();
        drive_upd(1'b1, 16'h5567, 16'h0078, 1'b1, 1'b0);
        bus.init_req = 1'b1;
        tick();
        bus.init_req = 1'b0;
        // keep offering a mispredicted update while the tables are being swept
        drive_upd(1'b1, 16'h9999, 16'h0000, 1'b1, 1'b1);
        n_checks++;
        if ({bus.tbl_we, bus.init_busy, bus.upd_ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL discard_enter: got we=%b busy=%b ready=%b, expected 0/1/0",
                     bus.tbl_we, bus.init_busy, bus.upd_ready);
        end
        for (int k = 0; k < 256; k++) begin
            bus.init_req = (k == 100);
            tick();
            n_checks++;
            if ({bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.tbl_target, bus.tbl_bht, bus.init_busy, bus.upd_ready}
                !== {1'b1, 8'(k), 8'hFF, 8'h00, 2'b01, 1'b1, 1'b0}) begin
                n_fail++;
                if (errs++ < 4)
                    $display("FAIL discard_sweep_%0d: got we=%b idx=%h tag=%h bht=%b busy=%b rdy=%b, expected 1/%h/ff/01/1/0",
                             k, bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.tbl_bht, bus.init_busy, bus.upd_ready, 8'(k));
            end
        end
        bus.init_req = 1'b0;
        drive_upd(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({bus.tbl_we, bus.init_busy, bus.upd_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL discard_done: got we=%b busy=%b ready=%b, expected 0/0/1",
                     bus.tbl_we, bus.init_busy, bus.upd_ready);
        end
        n_checks++;
        if (bus.mispred_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL discard_mispred: got %h expected 0000", bus.mispred_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int errs;
        errs = 0;
        drive_upd(1'b1, 16'h7788, 16'h0011, 1'b1, 1'b1);
        tick();
        drive_upd(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.tbl_target, bus.tbl_bht, bus.upd_ready, bus.init_busy, bus.mispred_cnt}
            !== {1'b0, 8'h00, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL async_reset: got we=%b idx=%h tag=%h tgt=%h bht=%b rdy=%b busy=%b cnt=%h, expected 0/00/00/00/01/0/1/0000",
                     bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.tbl_target, bus.tbl_bht,
                     bus.upd_ready, bus.init_busy, bus.mispred_cnt);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        for (int k = 0; k < 256; k++) begin
            tick();
            n_checks++;
            if ({bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.init_busy} !== {1'b1, 8'(k), 8'hFF, 1'b1}) begin
                n_fail++;
                if (errs++ < 4)
                    $display("FAIL restart_sweep_%0d: got we=%b idx=%h tag=%h busy=%b, expected 1/%h/ff/1",
                             k, bus.tbl_we, bus.tbl_idx, bus.tbl_tag, bus.init_busy, 8'(k));
            end
        end
        tick();
        n_checks++;
        if ({bus.tbl_we, bus.init_busy, bus.upd_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL restart_done: got we=%b busy=%b ready=%b, expected 0/0/1",
                     bus.tbl_we, bus.init_busy, bus.upd_ready);
        end
    endtask

    task automatic test_mispred_sat();
        drive_upd(1'b1, 16'h0102, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 65534; i++) tick();
        drive_upd(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (bus.mispred_cnt !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL mispred_preload: got %h expected fffe", bus.mispred_cnt);
        end
        drive_upd(1'b1, 16'h0102, 16'h0000, 1'b0, 1'b0);
        tick();
        drive_upd(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (bus.mispred_cnt !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL mispred_correct_pred: got %h expected fffe", bus.mispred_cnt);
        end
        drive_upd(1'b1, 16'h0102, 16'h0000, 1'b0, 1'b1);
        repeat (2) tick();
        drive_upd(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (bus.mispred_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL mispred_saturate: got %h expected ffff", bus.mispred_cnt);
        end
        drive_upd(1'b1, 16'h0102, 16'h0000, 1'b0, 1'b1);
        tick();
        drive_upd(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus.mispred_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL mispred_hold: got %h expected ffff", bus.mispred_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.init_req   = 1'b0;
        bus.tbl_rd_bht = 2'b01;
        drive_upd(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        test_reset();
        test_init_sweep();
        test_single_update();
        test_forwarding();
        test_saturation();
        test_back_to_back();
        test_init_discard();
        test_reset_mid();
        test_mispred_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
